// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU, with a one-entry
// result buffer per requester. Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters.

`ifndef ALU_NOP
`define ALU_NOP 4'hF
`endif

module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_aluop,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_aluop,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,

  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_output,
  input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  logic last_grant;
  logic elig0, elig1;
  logic grant0, grant1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the block infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    // A full buffer can still accept when it is drained in the same cycle.
    elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op    = `ALU_NOP;
    alu_data1 = '0;
    alu_data2 = '0;
    if (grant0) begin
      alu_op    = req0_aluop;
      alu_data1 = req0_data1;
      alu_data2 = req0_data2;
    end else if (grant1) begin
      alu_op    = req1_aluop;
      alu_data1 = req1_data1;
      alu_data2 = req1_data2;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the result payload is cleared as well as the valid bits, so outputs are defined after reset.
      last_grant  <= 1'b1;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;

      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_output;
        rsp0_zero   <= alu_zero;
      end else if (rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_output;
        rsp1_zero   <= alu_zero;
      end else if (rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model. Honours ALU_ARB_STATS_EN.

module tb_alu_arbiter;

  localparam int DW = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_aluop, req1_aluop;
  logic [DW-1:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic          rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_data1, alu_data2, alu_output;
  logic          alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_output(alu_output), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return DW'($signed(a) >>> b[4:0]);
      OP_SLT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: return {{(DW-1){1'b0}}, a < b};
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared ALU that the arbiter fronts.
  always_comb begin
    alu_output = ref_alu(alu_op, alu_data1, alu_data2);
    alu_zero   = (alu_output == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input int v0, input int v1, input int r0, input int r1,
                       input int o0, input int a0, input int b0, input int o1, input int a1, input int b1);
    rst        = r[0];
    req0_valid = v0[0];
    req1_valid = v1[0];
    rsp0_ready = r0[0];
    rsp1_ready = r1[0];
    req0_aluop = o0[3:0];
    req0_data1 = a0;
    req0_data2 = b0;
    req1_aluop = o1[3:0];
    req1_data1 = a1;
    req1_data2 = b1;
  endtask

  typedef struct {
    int rst, v0, v1, r0, r1;
    int op0, a0, b0, op1, a1, b1;
    int e_rdy0, e_rdy1, e_op, e_d1, e_d2;
    int e_rv0, e_res0, e_z0, e_rv1, e_res1, e_z1;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] sq[$];
    logic [DW-1:0] q0[$], q1[$];
    logic [DW-1:0] m_res[2];
    logic          m_zero[2];
    logic [DW-1:0] exp_res;
    int m_last, g, rr, grants;
    int vv[2], rd[2], op[2], da[2], db[2];
    bit el0, el1;
    int exp_op, exp_d1, exp_d2;

    //           rst v0 v1 r0 r1  op0     a0 b0  op1     a1 b1   rdy0 rdy1 op      d1 d2  rv0 res0 z0 rv1 res1 z1
    vecs[0]  = '{1, 1, 1, 0, 0, OP_ADD, 1, 2,  OP_ADD, 3, 4,   0, 0, OP_NOP, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, OP_ADD, 5, 7,  OP_ADD, 0, 0,   1, 0, OP_ADD, 5, 7,  1, 12, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, OP_ADD, 0, 0,  OP_ADD, 0, 0,   0, 0, OP_NOP, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 1, 1, OP_SUB, 9, 9,  OP_OR,  3, 4,   1, 0, OP_SUB, 9, 9,  1, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 1, 1, OP_SUB, 9, 9,  OP_OR,  3, 4,   0, 1, OP_OR,  3, 4,  0, 0, 1, 1, 7, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, OP_ADD, 0, 0,  OP_ADD, 10, 20, 0, 0, OP_NOP, 0, 0,  0, 0, 1, 1, 7, 0};
    vecs[6]  = '{0, 0, 1, 0, 1, OP_ADD, 0, 0,  OP_ADD, 10, 20, 0, 1, OP_ADD, 10, 20, 0, 0, 1, 1, 30, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, OP_ADD, 0, 0,  OP_ADD, 10, 20, 0, 0, OP_NOP, 0, 0,  0, 0, 1, 0, 30, 0};
    vecs[8]  = '{0, 1, 1, 0, 0, OP_XOR, 5, 5,  OP_AND, 12, 10, 1, 0, OP_XOR, 5, 5,  1, 0, 1, 0, 30, 0};
    vecs[9]  = '{0, 1, 1, 0, 0, OP_XOR, 5, 5,  OP_AND, 12, 10, 0, 1, OP_AND, 12, 10, 1, 0, 1, 1, 8, 0};
    vecs[10] = '{0, 1, 1, 0, 0, OP_XOR, 5, 5,  OP_AND, 12, 10, 0, 0, OP_NOP, 0, 0,  1, 0, 1, 1, 8, 0};
    vecs[11] = '{0, 1, 1, 1, 1, OP_XOR, 5, 5,  OP_AND, 12, 10, 1, 0, OP_XOR, 5, 5,  1, 0, 1, 0, 8, 0};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].r0, vecs[i].r1,
            vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].op1, vecs[i].a1, vecs[i].b1);
      #1;
      check($sformatf("vec%0d req0_ready", i), 32'(req0_ready), vecs[i].e_rdy0);
      check($sformatf("vec%0d req1_ready", i), 32'(req1_ready), vecs[i].e_rdy1);
      check($sformatf("vec%0d alu_op", i),     32'(alu_op),     vecs[i].e_op);
      check($sformatf("vec%0d alu_data1", i),  alu_data1,       vecs[i].e_d1);
      check($sformatf("vec%0d alu_data2", i),  alu_data2,       vecs[i].e_d2);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rsp0_valid", i),  32'(rsp0_valid), vecs[i].e_rv0);
      check($sformatf("vec%0d rsp0_result", i), rsp0_result,     vecs[i].e_res0);
      check($sformatf("vec%0d rsp0_zero", i),   32'(rsp0_zero),  vecs[i].e_z0);
      check($sformatf("vec%0d rsp1_valid", i),  32'(rsp1_valid), vecs[i].e_rv1);
      check($sformatf("vec%0d rsp1_result", i), rsp1_result,     vecs[i].e_res1);
      check($sformatf("vec%0d rsp1_zero", i),   32'(rsp1_zero),  vecs[i].e_z1);
    end

    // Streaming: eight back-to-back ADDs on requester 0 with its response always consumed.
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 1, 1, OP_ADD, i * 3, 100 + i, OP_ADD, 0, 0);
      sq.push_back(DW'(i * 3 + 100 + i));
      #1;
      if (req0_ready) grants++;
      @(posedge clk);
      #1;
      check($sformatf("stream%0d rsp0_valid", i), 32'(rsp0_valid), 1);
      exp_res = sq.pop_front();
      check($sformatf("stream%0d rsp0_result", i), rsp0_result, exp_res);
    end
    check("stream grant count", grants, 8);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, OP_ADD, 0, 0, OP_ADD, 0, 0);
    @(posedge clk);
    #1;
    check("stream drained rsp0_valid", 32'(rsp0_valid), 0);
    check("stream drained rsp0_result kept", rsp0_result, 7 * 3 + 100 + 7);

    // Reset landing on a grant cycle discards the in-flight result and restores req0 priority.
    @(negedge clk);
    drive(0, 1, 0, 0, 0, OP_ADD, 1, 1, OP_ADD, 0, 0);
    #1;
    check("rstmid pre grant", 32'(req0_ready), 1);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, OP_ADD, 2, 2, OP_ADD, 0, 0);
    #1;
    check("rstmid ready0 in reset", 32'(req0_ready), 0);
    check("rstmid alu_op in reset", 32'(alu_op), 32'(OP_NOP));
    @(posedge clk);
    #1;
    check("rstmid rsp0_valid cleared", 32'(rsp0_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, OP_ADD, 0, 0, OP_ADD, 0, 0);
      @(posedge clk);
      #1;
      check($sformatf("rstmid no pulse %0d", i), 32'(rsp0_valid), 0);
    end
    @(negedge clk);
    drive(0, 1, 1, 1, 1, OP_SUB, 4, 1, OP_ADD, 2, 2);
    #1;
    check("rstmid contention ready0", 32'(req0_ready), 1);
    check("rstmid contention ready1", 32'(req1_ready), 0);
    @(posedge clk);
    #1;
    check("rstmid contention rsp0_result", rsp0_result, 3);

`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    drive(1, 0, 0, 1, 1, OP_ADD, 0, 0, OP_ADD, 0, 0);
    @(posedge clk);
    #1;
    check("stats cnt0 after reset", 32'(grant_cnt0), 0);
    check("stats cnt1 after reset", 32'(grant_cnt1), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 1, 1, OP_ADD, 0, 0, OP_ADD, i, 1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 1, OP_ADD, 0, 0, OP_ADD, 0, 0);
    @(posedge clk);
    #1;
    check("stats grant_cnt1", 32'(grant_cnt1), 3);
    check("stats grant_cnt0", 32'(grant_cnt0), 0);
`endif

    // Randomized run against a model holding at most one pending result per requester.
    m_last = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rr = (c == 0 || $urandom_range(0, 39) == 0) ? 1 : 0;
      for (int n = 0; n < 2; n++) begin
        vv[n] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        rd[n] = ($urandom_range(0, 2) != 0) ? 1 : 0;
        op[n] = int'($urandom_range(0, 9));
        da[n] = int'($urandom);
        db[n] = ($urandom_range(0, 3) == 0) ? da[n] : int'($urandom);
      end
      drive(rr, vv[0], vv[1], rd[0], rd[1], op[0], da[0], db[0], op[1], da[1], db[1]);
      el0 = (vv[0] == 1) && (q0.size() == 0 || rd[0] == 1);
      el1 = (vv[1] == 1) && (q1.size() == 0 || rd[1] == 1);
      g = -1;
      if (rr == 0) begin
        if (el0 && el1) g = (m_last == 0) ? 1 : 0;
        else if (el0)   g = 0;
        else if (el1)   g = 1;
      end
      exp_op = (g < 0) ? int'(OP_NOP) : op[g];
      exp_d1 = (g < 0) ? 0 : da[g];
      exp_d2 = (g < 0) ? 0 : db[g];
      #1;
      check($sformatf("rnd%0d req0_ready", c), 32'(req0_ready), (g == 0) ? 1 : 0);
      check($sformatf("rnd%0d req1_ready", c), 32'(req1_ready), (g == 1) ? 1 : 0);
      check($sformatf("rnd%0d alu_op", c), 32'(alu_op), exp_op);
      check($sformatf("rnd%0d alu_data1", c), alu_data1, exp_d1);
      check($sformatf("rnd%0d alu_data2", c), alu_data2, exp_d2);
      @(posedge clk);
      #1;
      if (rr == 1) begin
        q0.delete();
        q1.delete();
        m_res[0] = '0;  m_res[1] = '0;
        m_zero[0] = 1'b0; m_zero[1] = 1'b0;
        m_last = 1;
      end else begin
        if (g >= 0) begin
          m_res[g]  = ref_alu(op[g][3:0], da[g], db[g]);
          m_zero[g] = (m_res[g] == '0);
          m_last    = g;
        end
        if (g == 0) begin q0.delete(); q0.push_back(m_res[0]); end
        else if (q0.size() != 0 && rd[0] == 1) q0.delete();
        if (g == 1) begin q1.delete(); q1.push_back(m_res[1]); end
        else if (q1.size() != 0 && rd[1] == 1) q1.delete();
      end
      check($sformatf("rnd%0d rsp0_valid", c), 32'(rsp0_valid), (q0.size() != 0) ? 1 : 0);
      check($sformatf("rnd%0d rsp1_valid", c), 32'(rsp1_valid), (q1.size() != 0) ? 1 : 0);
      check($sformatf("rnd%0d rsp0_result", c), rsp0_result, m_res[0]);
      check($sformatf("rnd%0d rsp1_result", c), rsp1_result, m_res[1]);
      check($sformatf("rnd%0d rsp0_zero", c), 32'(rsp0_zero), 32'(m_zero[0]));
      check($sformatf("rnd%0d rsp1_zero", c), 32'(rsp1_zero), 32'(m_zero[1]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port reqN_valid (N=0,1), input, 1: requester N presents an operation.
REQ-005 SHALL have port reqN_ready, output, 1: requester N's operation is accepted this cycle.
REQ-006 SHALL have port reqN_aluop, input, 4: ALU operation code per the `ALU_*` encodings in alu.vh.
REQ-007 SHALL have ports reqN_data1 and reqN_data2, input, DATA_W: operands.
REQ-008 SHALL have port rspN_valid, output, 1: the result buffer for requester N holds a result.
REQ-009 SHALL have port rspN_ready, input, 1: requester N consumes its result this cycle.
REQ-010 SHALL have port rspN_result, output, DATA_W: buffered result.
REQ-011 SHALL have port rspN_zero, output, 1: buffered zero flag.
REQ-012 SHALL have port alu_op, output, 4: operation driven to the shared alu.
REQ-013 SHALL have ports alu_data1 and alu_data2, output, DATA_W: operands driven to the shared alu.
REQ-014 SHALL have ports alu_output (input, DATA_W) and alu_zero (input, 1): combinational results returned by the alu.

Function
REQ-015 SHALL treat requester N as eligible when reqN_valid=1 and its buffer is empty or is drained this cycle (rspN_valid=1 and rspN_ready=1).
REQ-016 SHALL grant at most one requester per cycle; reqN_ready=1 only for the granted requester.
REQ-017 SHALL make reqN_ready depend combinationally on reqN_valid and buffer state, never on rspN_ready of the other requester.
REQ-018 SHALL, with both requesters eligible, grant the requester opposite to the last_grant register (round-robin).
REQ-019 SHALL, with one requester eligible, grant it regardless of last_grant.
REQ-020 SHALL update last_grant to the granted index on each grant, and hold it otherwise.
REQ-021 SHALL drive alu_op/alu_data1/alu_data2 from the granted requester combinationally, and drive `ALU_NOP with zero operands when no grant is made.
REQ-022 SHALL capture alu_output and alu_zero into buffer N at the clock edge ending a grant to N, setting rspN_valid=1 the next cycle: latency exactly 1 cycle.
REQ-023 SHALL hold rspN_valid, rspN_result and rspN_zero stable until the cycle rspN_ready=1, then clear rspN_valid unless a new grant to N reloads the buffer in the same cycle.
REQ-024 SHALL support back-to-back operation: one accepted operation per cycle per requester while rspN_ready stays 1.
REQ-025 SHALL leave rspN_result unchanged after drain (only rspN_valid clears).
REQ-026 SHALL NOT modify either buffer for a requester that is not granted.

Reset
REQ-027 SHALL, while rst=1, force req0_ready=req1_ready=0 and alu_op=`ALU_NOP with zero operands.
REQ-028 SHALL, at an edge with rst=1, set rspN_valid=0, rspN_result=0, rspN_zero=0 and last_grant=1, so that requester 0 wins the first contention.
REQ-029 SHALL discard any buffered result when rst asserts mid-operation; no rspN_valid pulse follows reset.

Configuration
REQ-030 SHALL, when macro ALU_ARB_STATS_EN is defined, add outputs grant_cnt0 and grant_cnt1, 16 bits each, counting grants per requester, saturating at 16'hFFFF and reset to 0.
REQ-031 SHALL, when ALU_ARB_STATS_EN is undefined, omit these ports and counters; all other behaviour is identical.

Verification
REQ-032 SHALL cover a single request: req0 ADD 5+7 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
REQ-033 SHALL cover contention after reset: both valid (req0 SUB 9-9, req1 OR 3|4) held for 2 cycles -> cycle 1 grants req0; cycle 2 grants req1; rsp0 = 0 with zero=1; rsp1 = 7.
REQ-034 SHALL cover backpressure: rsp1_valid=1, rsp1_ready=0, req1_valid=1 -> req1_ready=0 and alu_op=`ALU_NOP; raising rsp1_ready -> grant in the same cycle, new result next cycle.
REQ-035 SHALL cover streaming: req0 issuing 8 consecutive ADDs with rsp0_ready=1 -> 8 grants in 8 cycles and 8 in-order results.
REQ-036 SHALL cover reset mid-operation: rst asserted in the grant cycle -> no rsp0_valid afterwards; a subsequent contention grants req0 first.
REQ-037 SHALL cover stats with ALU_ARB_STATS_EN defined: 3 grants to req1 -> grant_cnt1=3 and grant_cnt0=0.
